// File: rtl/sbiu_pkg.sv
// Shared types and default widths for the SBIU downstream receiver.
package sbiu_pkg;

    localparam int ADR_W_DEF  = 8;
    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic [ADR_W_DEF-1:0]  src;
        logic [ADR_W_DEF-1:0]  dst;
        logic [DATA_W_DEF-1:0] data;
    } ds_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        GNT  = 1'b1
    } ds_rcvr_state_e;

endpackage

// File: rtl/sbiu_sync_fifo.sv
// Synchronous first-word fall-through FIFO; the head is always visible on dout.
module sbiu_sync_fifo
    import sbiu_pkg::*;
#(
    parameter type T     = ds_beat_t,
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           push,
    input  logic           pop,
    input  T               din,
    output T               dout,
    output logic [PTR_W:0] count,
    output logic           full,
    output logic           empty
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sbiu_ds_rcvr.sv
// SBIU downstream responder: grants the bus, stalls on a full FIFO and
// queues each accepted beat for the downstream consumer.
module sbiu_ds_rcvr
    import sbiu_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              bus_req,
    output logic              bus_gnt,
    output logic              wait_sig,
    input  logic              valid,
    input  logic [ADR_W-1:0]  src_adr_out,
    input  logic [ADR_W-1:0]  dst_adr_out,
    input  logic [DATA_W-1:0] data_out,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ADR_W-1:0]  o_src,
    output logic [ADR_W-1:0]  o_dst,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              err_proto
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADR_W-1:0]  src;
        logic [ADR_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } beat_t;

    ds_rcvr_state_e  state;
    ds_rcvr_state_e  state_nxt;
    beat_t           beat_in;
    beat_t           beat_out;
    logic [PTR_W:0]  fifo_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            pop;
    logic            xfer_done;

    assign bus_gnt   = (state == GNT);
    // Stall depends only on the registered count, so a same-cycle pop never frees a slot.
    assign wait_sig  = bus_gnt && fifo_full;
    assign accept    = valid && bus_gnt && !wait_sig;
    assign pop       = o_valid && o_ready;
    assign xfer_done = (state == GNT) && !bus_req;
    assign beat_in   = '{src: src_adr_out, dst: dst_adr_out, data: data_out};

    assign o_valid = !fifo_empty;
    assign o_src   = beat_out.src;
    assign o_dst   = beat_out.dst;
    assign o_data  = beat_out.data;

    sbiu_sync_fifo #(
        .T     (beat_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (accept),
        .pop   (pop),
        .din   (beat_in),
        .dout  (beat_out),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next-state is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus_req && (fifo_cnt < (PTR_W+1)'(DEPTH))) state_nxt = GNT;
            GNT:  if (!bus_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            xfer_cnt  <= '0;
            beat_cnt  <= '0;
            err_proto <= 1'b0;
        end else begin
            if (xfer_done)          xfer_cnt  <= xfer_cnt + CNT_W'(1);
            if (accept)             beat_cnt  <= beat_cnt + CNT_W'(1);
            if (valid && !bus_gnt)  err_proto <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sbiu_ds_rcvr.sv
// Randomized scoreboard bench for sbiu_ds_rcvr against a queue-based reference model.
module tb_sbiu_ds_rcvr;

    localparam int ADR_W  = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [ADR_W-1:0]  src;
        logic [ADR_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } beat_s;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              bus_req = 1'b0;
    logic              bus_gnt;
    logic              wait_sig;
    logic              valid = 1'b0;
    logic [ADR_W-1:0]  src_adr_out = '0;
    logic [ADR_W-1:0]  dst_adr_out = '0;
    logic [DATA_W-1:0] data_out = '0;
    logic              o_valid;
    logic              o_ready = 1'b0;
    logic [ADR_W-1:0]  o_src;
    logic [ADR_W-1:0]  o_dst;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  xfer_cnt;
    logic [CNT_W-1:0]  beat_cnt;
    logic              err_proto;

    int passed = 0;
    int total  = 0;

    // Reference model: a queue of outstanding beats plus grant, counters and error flag.
    beat_s            exp_q[$];
    bit               m_gnt  = 0;
    bit               m_err  = 0;
    logic [CNT_W-1:0] m_xfer = '0;
    logic [CNT_W-1:0] m_beat = '0;

    sbiu_ds_rcvr #(
        .ADR_W (ADR_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .wait_sig    (wait_sig),
        .valid       (valid),
        .src_adr_out (src_adr_out),
        .dst_adr_out (dst_adr_out),
        .data_out    (data_out),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_src       (o_src),
        .o_dst       (o_dst),
        .o_data      (o_data),
        .xfer_cnt    (xfer_cnt),
        .beat_cnt    (beat_cnt),
        .err_proto   (err_proto)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Monitor: compares DUT state to the model, pops on consumer handshake,
    // then advances the model by the upcoming clock edge.
    always @(negedge clk) begin
        if (!rst_b) begin
            exp_q.delete();
            m_gnt  = 0;
            m_err  = 0;
            m_xfer = '0;
            m_beat = '0;
        end else begin
            int    n;
            bit    m_wait;
            bit    acc;
            beat_s e;
            n      = exp_q.size();
            m_wait = m_gnt && (n == DEPTH);
            check("bus_gnt",   bus_gnt,   m_gnt);
            check("wait_sig",  wait_sig,  m_wait);
            check("o_valid",   o_valid,   n > 0);
            check("xfer_cnt",  xfer_cnt,  m_xfer);
            check("beat_cnt",  beat_cnt,  m_beat);
            check("err_proto", err_proto, m_err);
            if (o_ready && n > 0) begin
                e = exp_q.pop_front();
                check("o_src",  o_src,  e.src);
                check("o_dst",  o_dst,  e.dst);
                check("o_data", o_data, e.data);
            end
            acc = valid && m_gnt && !m_wait;
            if (acc) begin
                exp_q.push_back('{src: src_adr_out, dst: dst_adr_out, data: data_out});
                m_beat = m_beat + 1'b1;
            end
            if (valid && !m_gnt) m_err = 1;
            if (m_gnt && !bus_req) begin
                m_gnt  = 0;
                m_xfer = m_xfer + 1'b1;
            end else if (!m_gnt && bus_req && n < DEPTH) begin
                m_gnt = 1;
            end
        end
    end

    task automatic wait_gnt();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_gnt) return;
        end
        check("gnt_wait", bus_gnt, 1);
    endtask

    // Bus master behaviour: present a beat and hold it while stalled.
    task automatic send_beat(input logic [ADR_W-1:0] s, input logic [ADR_W-1:0] d,
                             input logic [DATA_W-1:0] dat);
        @(posedge clk); #1;
        valid = 1'b1; src_adr_out = s; dst_adr_out = d; data_out = dat;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_gnt && !wait_sig) return;
            @(posedge clk); #1;
        end
        check("beat_accept_wait", wait_sig, 0);
    endtask

    task automatic idle_bus();
        @(posedge clk); #1;
        valid = 1'b0;
        bus_req = 1'b0;
    endtask

    task automatic drain(input int n);
        @(posedge clk); #1;
        valid = 1'b0; bus_req = 1'b0; o_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 o_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;

        // Reset mid-transfer
        @(posedge clk); #1 bus_req = 1'b1;
        wait_gnt();
        for (int i = 0; i < 3; i++) send_beat(ADR_W'(i), ADR_W'(i + 1), $urandom);
        @(posedge clk); #1 valid = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        check("rst_bus_gnt",  bus_gnt,  0);
        check("rst_o_valid",  o_valid,  0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        bus_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;

        // Single beat
        @(posedge clk); #1 bus_req = 1'b1;
        wait_gnt();
        send_beat(8'h12, 8'h34, 32'hDEADBEEF);
        idle_bus();
        #1 check("single_o_data", o_data, 32'hDEADBEEF);
        drain(3);

        // Backpressure: ten beats into an unread FIFO, two single-cycle pops
        @(posedge clk); #1 bus_req = 1'b1;
        wait_gnt();
        fork
            for (int i = 0; i < 10; i++) send_beat(ADR_W'(i), ADR_W'(8'h80 + i), DATA_W'(i));
            begin
                repeat (15) @(posedge clk);
                #1 o_ready = 1'b1;
                @(posedge clk); #1 o_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 o_ready = 1'b1;
                @(posedge clk); #1 o_ready = 1'b0;
            end
        join
        idle_bus();
        drain(12);

        // Full FIFO blocks a new grant until one pop
        @(posedge clk); #1 bus_req = 1'b1;
        wait_gnt();
        for (int i = 0; i < DEPTH; i++) send_beat($urandom, $urandom, $urandom);
        idle_bus();
        @(posedge clk); #1 bus_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("full_no_gnt", bus_gnt, 0);
        o_ready = 1'b1;
        @(posedge clk); #1 o_ready = 1'b0;
        @(posedge clk); #1 check("gnt_after_pop", bus_gnt, 1);
        idle_bus();
        drain(10);

        // Protocol error, then a good transfer
        @(posedge clk); #1 valid = 1'b1; data_out = $urandom;
        @(posedge clk); #1 valid = 1'b0;
        bus_req = 1'b1;
        wait_gnt();
        send_beat($urandom, $urandom, $urandom);
        idle_bus();
        drain(3);

        // Streaming with simultaneous push and pop
        @(posedge clk); #1 bus_req = 1'b1; o_ready = 1'b1;
        wait_gnt();
        for (int i = 0; i < 20; i++) send_beat($urandom, $urandom, $urandom);
        idle_bus();
        drain(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            bus_req     = ($urandom_range(3) != 0);
            valid       = $urandom_range(1);
            o_ready     = ($urandom_range(2) == 0);
            src_adr_out = $urandom;
            dst_adr_out = $urandom;
            data_out    = $urandom;
        end
        drain(DEPTH + 4);
        @(negedge clk);
        check("final_empty", o_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
